// File: rtl/hdr_insert_arbiter_pkg.sv
// Shared types and width helpers for the header-insert arbiter.
package hdr_ins_pkg;

    // Arbiter FSM: waiting for a header, presenting it, waiting for packet end.
    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StHdr  = 2'd1,
        StPkt  = 2'd2
    } state_e;

    // Byte-count width for a given number of bytes per beat.
    function automatic int unsigned cnt_wd(input int unsigned byte_wd);
        return $clog2(byte_wd) + 1;
    endfunction

    // Source-index width for a given number of requesters.
    function automatic int unsigned src_id_wd(input int unsigned num_src);
        return $clog2(num_src);
    endfunction

    localparam int unsigned DefNumSrc     = 4;
    localparam int unsigned DefDataWd     = 32;
    localparam int unsigned DefDataByteWd = DefDataWd / 8;
    localparam int unsigned DefByteCntWd  = $clog2(DefDataByteWd);
    localparam int unsigned CNT_WD        = DefByteCntWd + 1;
    localparam int unsigned SRC_ID_WD     = $clog2(DefNumSrc);

endpackage

// File: rtl/hdr_insert_arbiter_if.sv
// Bundle of header-request, insert-channel and packet-monitor signals.
interface hdr_insert_arbiter_if
    import hdr_ins_pkg::*;
#(
    parameter int unsigned NUM_SRC      = DefNumSrc,
    parameter int unsigned DATA_WD      = DefDataWd,
    parameter int unsigned DATA_BYTE_WD = DATA_WD / 8,
    parameter int unsigned BYTE_CNT_WD  = $clog2(DATA_BYTE_WD),
    parameter int unsigned ID_WD        = src_id_wd(NUM_SRC)
);

    // Header requesters
    logic [NUM_SRC-1:0]                   hdr_valid_s;
    logic [NUM_SRC*DATA_WD-1:0]           hdr_data_s;
    logic [NUM_SRC*DATA_BYTE_WD-1:0]      hdr_keep_s;
    logic [NUM_SRC*(BYTE_CNT_WD+1)-1:0]   hdr_byte_cnt_s;
    logic [NUM_SRC-1:0]                   hdr_ready_s;

    // Insert channel toward the stream-insertion core
    logic                                 ins_valid_m;
    logic [DATA_WD-1:0]                   ins_data_m;
    logic [DATA_BYTE_WD-1:0]              ins_keep_m;
    logic [BYTE_CNT_WD:0]                 ins_byte_insert_cnt;
    logic                                 ins_ready_m;

    // Taps on the insert core's output data stream
    logic                                 pkt_valid;
    logic                                 pkt_ready;
    logic                                 pkt_last;

    // Status
    logic [ID_WD-1:0]                     grant_id;
    logic                                 busy;
    logic                                 err_orphan_last;

    // Environment side: header producers, insert core and monitor taps.
    modport master (
        output hdr_valid_s, hdr_data_s, hdr_keep_s, hdr_byte_cnt_s,
        output ins_ready_m, pkt_valid, pkt_ready, pkt_last,
        input  hdr_ready_s, ins_valid_m, ins_data_m, ins_keep_m, ins_byte_insert_cnt,
        input  grant_id, busy, err_orphan_last
    );

    // Arbiter side.
    modport slave (
        input  hdr_valid_s, hdr_data_s, hdr_keep_s, hdr_byte_cnt_s,
        input  ins_ready_m, pkt_valid, pkt_ready, pkt_last,
        output hdr_ready_s, ins_valid_m, ins_data_m, ins_keep_m, ins_byte_insert_cnt,
        output grant_id, busy, err_orphan_last
    );

endinterface

// File: rtl/hdr_rr_pick.sv
// Combinational round-robin picker: first request at or after the pointer, wrapping.
module hdr_rr_pick #(
    parameter int unsigned NUM_SRC = 4,
    parameter int unsigned ID_WD   = 2
) (
    input  logic [NUM_SRC-1:0] req_i,
    input  logic [ID_WD-1:0]   ptr_i,
    output logic [NUM_SRC-1:0] gnt_o,
    output logic [ID_WD-1:0]   win_o,
    output logic               any_o
);

    // Scan offsets from farthest to nearest so the nearest request overwrites last.
    always_comb begin
        int idx;
        idx   = 0;
        gnt_o = '0;
        win_o = '0;
        any_o = |req_i;
        for (int k = int'(NUM_SRC) - 1; k >= 0; k--) begin
            idx = (int'(ptr_i) + k) % int'(NUM_SRC);
            if (req_i[idx]) begin
                win_o = ID_WD'(idx);
            end
        end
        if (any_o) begin
            gnt_o[win_o] = 1'b1;
        end
    end

endmodule

// File: rtl/hdr_insert_arbiter.sv
// Round-robin owner of the header-insert port: accepts one header, presents it,
// then holds the grant until the matching packet's last beat has gone by.
module hdr_insert_arbiter
    import hdr_ins_pkg::*;
#(
    parameter int unsigned NUM_SRC      = DefNumSrc,
    parameter int unsigned DATA_WD      = DefDataWd,
    parameter int unsigned DATA_BYTE_WD = DATA_WD / 8,
    parameter int unsigned BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
    input logic clk,
    input logic rst,
    hdr_insert_arbiter_if.slave bus
);

    localparam int unsigned CntWd = BYTE_CNT_WD + 1;
    localparam int unsigned IdWd  = src_id_wd(NUM_SRC);

    state_e                  state_q;
    logic [IdWd-1:0]         rr_ptr_q;
    logic [IdWd-1:0]         grant_q;
    logic                    ins_valid_q;
    logic [DATA_WD-1:0]      data_q;
    logic [DATA_BYTE_WD-1:0] keep_q;
    logic [CntWd-1:0]        cnt_q;
    logic                    err_q;

    logic [NUM_SRC-1:0]      pick_gnt;
    logic [IdWd-1:0]         pick_win;
    logic                    pick_any;

    logic [DATA_WD-1:0]      win_data;
    logic [DATA_BYTE_WD-1:0] win_keep;
    logic [CntWd-1:0]        win_cnt;
    logic                    win_cnt_ok;
    logic                    last_hs;
    logic                    hdr_hs;

    // Successor index with wrap from NUM_SRC-1 back to 0.
    function automatic logic [IdWd-1:0] inc_wrap(input logic [IdWd-1:0] x);
        if (int'(x) == int'(NUM_SRC) - 1) begin
            return '0;
        end
        return x + IdWd'(1);
    endfunction

    hdr_rr_pick #(
        .NUM_SRC (NUM_SRC),
        .ID_WD   (IdWd)
    ) u_pick (
        .req_i (bus.hdr_valid_s),
        .ptr_i (rr_ptr_q),
        .gnt_o (pick_gnt),
        .win_o (pick_win),
        .any_o (pick_any)
    );

    // Select the winning source's header fields and qualify its byte count.
    always_comb begin
        win_data   = bus.hdr_data_s[int'(pick_win)*int'(DATA_WD) +: DATA_WD];
        win_keep   = bus.hdr_keep_s[int'(pick_win)*int'(DATA_BYTE_WD) +: DATA_BYTE_WD];
        win_cnt    = bus.hdr_byte_cnt_s[int'(pick_win)*int'(CntWd) +: CntWd];
        // Zero or oversize counts are accepted from the source but never forwarded.
        win_cnt_ok = (win_cnt != '0) && (win_cnt <= CntWd'(DATA_BYTE_WD));
        last_hs    = bus.pkt_valid && bus.pkt_ready && bus.pkt_last;
        hdr_hs     = ins_valid_q && bus.ins_ready_m;
    end

    // Arbitration FSM with registered header outputs and grant pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            rr_ptr_q    <= '0;
            grant_q     <= '0;
            ins_valid_q <= 1'b0;
            data_q      <= '0;
            keep_q      <= '0;
            cnt_q       <= '0;
            err_q       <= 1'b0;
        end else begin
            err_q <= (state_q == StIdle) && last_hs;
            case (state_q)
                StIdle: begin
                    if (pick_any) begin
                        grant_q <= pick_win;
                        data_q  <= win_data;
                        keep_q  <= win_keep;
                        cnt_q   <= win_cnt;
                        if (win_cnt_ok) begin
                            state_q     <= StHdr;
                            ins_valid_q <= 1'b1;
                        end else begin
                            rr_ptr_q <= inc_wrap(pick_win);
                        end
                    end
                end
                StHdr: begin
                    // A last beat without the header handshake belongs to no grant.
                    if (hdr_hs) begin
                        ins_valid_q <= 1'b0;
                        if (last_hs) begin
                            state_q  <= StIdle;
                            rr_ptr_q <= inc_wrap(grant_q);
                        end else begin
                            state_q <= StPkt;
                        end
                    end
                end
                StPkt: begin
                    if (last_hs) begin
                        state_q  <= StIdle;
                        rr_ptr_q <= inc_wrap(grant_q);
                    end
                end
                default: begin
                    state_q     <= StIdle;
                    ins_valid_q <= 1'b0;
                end
            endcase
        end
    end

    // Accept pulse only while idle and never during reset.
    assign bus.hdr_ready_s         = ((state_q == StIdle) && !rst) ? pick_gnt : '0;
    assign bus.ins_valid_m         = ins_valid_q;
    assign bus.ins_data_m          = data_q;
    assign bus.ins_keep_m          = keep_q;
    assign bus.ins_byte_insert_cnt = cnt_q;
    assign bus.grant_id            = grant_q;
    assign bus.busy                = (state_q != StIdle);
    assign bus.err_orphan_last     = err_q;

endmodule

// File: tb/tb_hdr_insert_arbiter.sv
// Self-checking bench: directed vector table, fairness sequence, randomized run vs model.
module tb_hdr_insert_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int BW = 4;
    localparam int CW = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    hdr_insert_arbiter_if #(
        .NUM_SRC      (N),
        .DATA_WD      (DW),
        .DATA_BYTE_WD (BW),
        .BYTE_CNT_WD  (2)
    ) bus ();

    hdr_insert_arbiter #(
        .NUM_SRC      (N),
        .DATA_WD      (DW),
        .DATA_BYTE_WD (BW),
        .BYTE_CNT_WD  (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_chk  = 0;
    int n_pass = 0;

    // Stimulus state
    logic [N-1:0]  vld;
    logic [DW-1:0] sdata [N];
    logic [BW-1:0] skeep [N];
    logic [CW-1:0] scnt  [N];
    logic          ins_rdy, pv, pr, pl;

    // Reference model state (spec-level: mode 0 idle, 1 header, 2 packet)
    int            m_st, m_ptr, m_grant;
    logic [DW-1:0] m_data;
    logic [BW-1:0] m_keep;
    logic [CW-1:0] m_cnt;
    logic          m_err;

    typedef struct {
        logic       rst;
        logic [3:0] vld;
        logic [11:0] cnts;
        logic       ins_rdy;
        logic       lst;
        logic [3:0] e_rdy;
        logic       e_ivld;
        logic [1:0] e_gid;
        logic       e_busy;
        logic       e_err;
    } vec_t;

    vec_t tbl [19];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic apply();
        bus.hdr_valid_s = vld;
        for (int i = 0; i < N; i++) begin
            bus.hdr_data_s[i*DW +: DW]     = sdata[i];
            bus.hdr_keep_s[i*BW +: BW]     = skeep[i];
            bus.hdr_byte_cnt_s[i*CW +: CW] = scnt[i];
        end
        bus.ins_ready_m = ins_rdy;
        bus.pkt_valid   = pv;
        bus.pkt_ready   = pr;
        bus.pkt_last    = pl;
    endtask

    // First valid source at or after p, wrapping; -1 if none.
    function automatic int pick(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++) begin
            if (v[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    task automatic model_check();
        int w;
        logic [3:0] er;
        w  = pick(vld, m_ptr);
        er = (m_st == 0 && !rst && w >= 0) ? 4'(1 << w) : 4'd0;
        check("rnd_hdr_ready", 32'(bus.hdr_ready_s), 32'(er));
        check("rnd_ins_valid", 32'(bus.ins_valid_m), 32'(m_st == 1));
        check("rnd_ins_data", bus.ins_data_m, m_data);
        check("rnd_ins_keep", 32'(bus.ins_keep_m), 32'(m_keep));
        check("rnd_ins_cnt", 32'(bus.ins_byte_insert_cnt), 32'(m_cnt));
        check("rnd_grant_id", 32'(bus.grant_id), 32'(m_grant));
        check("rnd_busy", 32'(bus.busy), 32'(m_st != 0));
        check("rnd_err_orphan", 32'(bus.err_orphan_last), 32'(m_err));
    endtask

    // Advance the model across one rising edge; retires accepted source requests.
    task automatic model_update();
        int w;
        logic lh, nerr;
        if (rst) begin
            m_st = 0; m_ptr = 0; m_grant = 0;
            m_data = '0; m_keep = '0; m_cnt = '0; m_err = 1'b0;
        end else begin
            lh   = pv && pr && pl;
            nerr = (m_st == 0) && lh;
            case (m_st)
                0: begin
                    w = pick(vld, m_ptr);
                    if (w >= 0) begin
                        m_grant = w;
                        m_data  = sdata[w];
                        m_keep  = skeep[w];
                        m_cnt   = scnt[w];
                        if (scnt[w] >= 1 && scnt[w] <= BW) m_st = 1;
                        else m_ptr = (w + 1) % N;
                        vld[w] = 1'b0;
                    end
                end
                1: if (ins_rdy) begin
                    if (lh) begin m_st = 0; m_ptr = (m_grant + 1) % N; end
                    else m_st = 2;
                end
                default: if (lh) begin m_st = 0; m_ptr = (m_grant + 1) % N; end
            endcase
            m_err = nerr;
        end
    endtask

    task automatic set_row(input int i, input logic r, input logic [3:0] v, input logic [11:0] c,
                           input logic ir, input logic l, input logic [3:0] er, input logic eiv,
                           input logic [1:0] eg, input logic eb, input logic ee);
        tbl[i] = '{r, v, c, ir, l, er, eiv, eg, eb, ee};
    endtask

    initial begin
        rst = 1'b1; vld = '0; ins_rdy = 0; pv = 1; pr = 1; pl = 0;
        for (int i = 0; i < N; i++) begin
            sdata[i] = 32'hA5A5_0000 | 32'(i);
            skeep[i] = 4'hF;
            scnt[i]  = 3'd4;
        end
        //          rst vld     cnts     rdy lst  e_rdy   ivld gid busy err
        set_row( 0, 1, 4'b0101, 12'h924, 0, 0, 4'b0000, 0, 0, 0, 0);
        set_row( 1, 0, 4'b0101, 12'h924, 0, 0, 4'b0001, 0, 0, 0, 0);
        set_row( 2, 0, 4'b0100, 12'h924, 1, 0, 4'b0000, 1, 0, 1, 0);
        set_row( 3, 0, 4'b0100, 12'h924, 0, 0, 4'b0000, 0, 0, 1, 0);
        set_row( 4, 0, 4'b0100, 12'h924, 0, 1, 4'b0000, 0, 0, 1, 0);
        set_row( 5, 0, 4'b0100, 12'h924, 0, 0, 4'b0100, 0, 0, 0, 0);
        set_row( 6, 0, 4'b0000, 12'h924, 1, 1, 4'b0000, 1, 2, 1, 0);
        set_row( 7, 0, 4'b1010, 12'h904, 0, 0, 4'b1000, 0, 2, 0, 0);
        set_row( 8, 0, 4'b0010, 12'h904, 1, 0, 4'b0000, 1, 3, 1, 0);
        set_row( 9, 0, 4'b0010, 12'h904, 0, 1, 4'b0000, 0, 3, 1, 0);
        set_row(10, 0, 4'b0010, 12'h904, 0, 0, 4'b0010, 0, 3, 0, 0);
        set_row(11, 0, 4'b0110, 12'h904, 0, 0, 4'b0100, 0, 1, 0, 0);
        set_row(12, 0, 4'b0010, 12'h904, 0, 1, 4'b0000, 1, 2, 1, 0);
        set_row(13, 0, 4'b0010, 12'h904, 1, 0, 4'b0000, 1, 2, 1, 0);
        set_row(14, 0, 4'b0010, 12'h904, 0, 0, 4'b0000, 0, 2, 1, 0);
        set_row(15, 1, 4'b0010, 12'h904, 0, 0, 4'b0000, 0, 2, 1, 0);
        set_row(16, 0, 4'b0000, 12'h904, 0, 1, 4'b0000, 0, 0, 0, 0);
        set_row(17, 0, 4'b0000, 12'h904, 0, 0, 4'b0000, 0, 0, 0, 1);
        set_row(18, 0, 4'b1111, 12'h924, 0, 0, 4'b0001, 0, 0, 0, 0);

        // Directed vectors
        for (int i = 0; i < 19; i++) begin
            rst = tbl[i].rst; vld = tbl[i].vld; ins_rdy = tbl[i].ins_rdy; pl = tbl[i].lst;
            for (int s = 0; s < N; s++) scnt[s] = tbl[i].cnts[s*CW +: CW];
            apply();
            @(negedge clk);
            check("vec_hdr_ready", 32'(bus.hdr_ready_s), 32'(tbl[i].e_rdy));
            check("vec_ins_valid", 32'(bus.ins_valid_m), 32'(tbl[i].e_ivld));
            check("vec_grant_id", 32'(bus.grant_id), 32'(tbl[i].e_gid));
            check("vec_busy", 32'(bus.busy), 32'(tbl[i].e_busy));
            check("vec_err_orphan", 32'(bus.err_orphan_last), 32'(tbl[i].e_err));
            if (tbl[i].e_ivld) begin
                check("vec_ins_data", bus.ins_data_m, 32'hA5A5_0000 | 32'(tbl[i].e_gid));
                check("vec_ins_cnt", 32'(bus.ins_byte_insert_cnt), 32'd4);
            end
            if (i > 0 && tbl[i-1].rst) begin
                check("rst_ins_data", bus.ins_data_m, 32'h0);
                check("rst_ins_keep", 32'(bus.ins_keep_m), 32'h0);
                check("rst_ins_cnt", 32'(bus.ins_byte_insert_cnt), 32'h0);
            end
            @(posedge clk); #1;
        end

        // Fairness: all sources always valid, 3-beat packets
        rst = 1'b1; vld = '0; ins_rdy = 0; pl = 0;
        for (int s = 0; s < N; s++) scnt[s] = 3'd4;
        apply(); @(posedge clk); #1;
        rst = 1'b0; vld = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            ins_rdy = 0; pl = 0; apply();
            @(negedge clk);
            check("rr_fair_accept", 32'(bus.hdr_ready_s), 32'(1 << (k % N)));
            @(posedge clk); #1;
            ins_rdy = 1; apply();
            @(negedge clk);
            check("rr_fair_ins_valid", 32'(bus.ins_valid_m), 32'd1);
            check("rr_fair_grant", 32'(bus.grant_id), 32'(k % N));
            @(posedge clk); #1;
            ins_rdy = 0; apply();
            @(negedge clk);
            check("rr_fair_no_ready", 32'(bus.hdr_ready_s), 32'd0);
            @(posedge clk); #1;
            pl = 1; apply();
            @(posedge clk); #1;
        end

        // Randomized run against the reference model
        rst = 1'b1; vld = '0; ins_rdy = 0; pv = 0; pr = 0; pl = 0;
        apply();
        @(negedge clk);
        @(posedge clk); model_update(); #1;
        for (int c = 0; c < 400; c++) begin
            for (int s = 0; s < N; s++) begin
                if (!vld[s] && $urandom_range(2, 0) == 0) begin
                    vld[s]   = 1'b1;
                    sdata[s] = $urandom;
                    skeep[s] = 4'($urandom);
                    scnt[s]  = 3'($urandom_range(5, 0));
                end
            end
            rst     = ($urandom_range(63, 0) == 0);
            ins_rdy = 1'($urandom);
            pv      = 1'($urandom);
            pr      = 1'($urandom);
            pl      = ($urandom_range(2, 0) == 0);
            apply();
            @(negedge clk);
            model_check();
            @(posedge clk);
            model_update();
            #1;
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/hdr_insert_arbiter.md
# hdr_insert_arbiter

Round-robin scheduler that shares the single header-insert port of the header-insertion datapath between `NUM_SRC` header requesters. It accepts one header from the winning source, presents it on the AXIS insert interface, then holds the grant until the associated data packet's last beat has been transferred. Only then does it arbitrate again. It sits between the header producers and the insert channel (`ins_*`) of the stream-insertion core, and monitors that core's data stream for packet boundaries.

## Interface
Parameters:
- `NUM_SRC`, 4: number of header requesters; must be 2 or more.
- `DATA_WD`, 32: header data width in bits.
- `DATA_BYTE_WD`, `DATA_WD/8`: header bytes per beat.
- `BYTE_CNT_WD`, `$clog2(DATA_BYTE_WD)`: byte-count index width; counts use `BYTE_CNT_WD+1` bits.

Ports:
- `clk`  in  1  single clock, all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `hdr_valid_s`  in  `NUM_SRC`  per-source header valid.
- `hdr_data_s`  in  `NUM_SRC*DATA_WD`  header data; source i occupies slice i.
- `hdr_keep_s`  in  `NUM_SRC*DATA_BYTE_WD`  header byte keep, per source.
- `hdr_byte_cnt_s`  in  `NUM_SRC*(BYTE_CNT_WD+1)`  valid header bytes, per source.
- `hdr_ready_s`  out  `NUM_SRC`  one-hot accept pulse to the granted source.
- `ins_valid_m`  out  1  header valid toward the insert core.
- `ins_data_m`  out  `DATA_WD`  registered header data.
- `ins_keep_m`  out  `DATA_BYTE_WD`  registered header keep.
- `ins_byte_insert_cnt`  out  `BYTE_CNT_WD+1`  registered header byte count.
- `ins_ready_m`  in  1  insert core accepts the header.
- `pkt_valid`, `pkt_ready`, `pkt_last`  in  1 each  monitor taps of the insert core's output data stream.
- `grant_id`  out  `$clog2(NUM_SRC)`  current or last granted source.
- `busy`  out  1  high in every state except IDLE.
- `err_orphan_last`  out  1  one-cycle pulse on a packet-last handshake while IDLE.

## Operation
- FSM states: IDLE, HDR, PKT.
- IDLE:
  - If any `hdr_valid_s` bit is set, pick the first valid source at or after `rr_ptr`, wrapping modulo `NUM_SRC`.
  - In the same cycle, assert `hdr_ready_s[win]` combinationally and capture that source's data, keep and cnt into the output registers.
  - Load `grant_id` with the winner.
  - If the captured cnt is 1 to `DATA_BYTE_WD`: go to HDR.
  - If the captured cnt is 0 or greater than `DATA_BYTE_WD`: drop the header (it is accepted but not forwarded), set `rr_ptr=win+1`, and stay in IDLE.
- HDR:
  - `ins_valid_m=1`; the output registers stay stable until `ins_valid_m && ins_ready_m`, then go to PKT.
  - If a `pkt_valid&&pkt_ready&&pkt_last` handshake lands in the same cycle as the header handshake, go straight to IDLE and set `rr_ptr=grant_id+1`.
- PKT:
  - `ins_valid_m=0`.
  - On `pkt_valid&&pkt_ready&&pkt_last`, set `rr_ptr=grant_id+1` and go to IDLE.
- Packet-last handshakes during HDR without the header handshake are ignored.
- Packet-last handshakes in IDLE pulse `err_orphan_last` and change no state.
- `rr_ptr` wraps from `NUM_SRC-1` to 0.
- `hdr_ready_s` is 0 outside IDLE.
- Reset values: state=IDLE, `rr_ptr=0`, `grant_id=0`, `ins_valid_m=0`, `ins_data_m=0`, `ins_keep_m=0`, `ins_byte_insert_cnt=0`, `hdr_ready_s=0`, `busy=0`, `err_orphan_last=0`.
- Reset asserted mid-packet returns to IDLE next edge and abandons the grant; no ready pulse is issued while `rst=1`.

## Timing
- Request visible in IDLE at cycle t: `hdr_ready_s` pulses in t, and `ins_valid_m=1` from t+1.
- Minimum grant-to-grant period is 2 cycles: the header and last handshakes occur together at t+1, and the next accept happens at t+2.
- The IDLE→HDR→PKT→IDLE path takes 3 or more cycles.
- Header outputs are registered with no combinational path from `ins_ready_m`. `hdr_ready_s` depends combinationally on `hdr_valid_s` and state only.
- Sources must hold valid and data stable until their `hdr_ready_s` pulse.

## Structure
- Package `hdr_ins_pkg`:
  - state enum (IDLE, HDR, PKT);
  - localparams for the count width and `SRC_ID_WD=$clog2(NUM_SRC)`.
- Sub-module `hdr_rr_pick`: combinational round-robin picker.
  - Inputs: request vector and pointer.
  - Outputs: one-hot grant, winner index and any-request.
- The top level holds the FSM, `rr_ptr`, the output registers and the monitor.

## Test plan
- Sources 0 and 2 valid, `rr_ptr=0` → source 0 is accepted in cycle 0 and `ins_valid_m` rises in cycle 1. After its `pkt_last` handshake, source 2 is granted, then the pointer becomes 3.
- All 4 sources are continuously valid and each packet is 3 beats → grants follow 0,1,2,3,0 and no source is starved.
- Header with cnt=0 from source 1 → `hdr_ready_s[1]` pulses, `ins_valid_m` stays 0, `rr_ptr=2`.
- `ins_ready_m` and `pkt_last` handshake in the same cycle in HDR → the next cycle is IDLE, and a new accept is possible 2 cycles after the previous accept.
- `pkt_last` handshake while IDLE → `err_orphan_last` is a 1-cycle pulse and the state is unchanged.
- `rst` asserted in PKT → the next cycle is IDLE with `rr_ptr=0`, all outputs at reset values, and `ins_valid_m=0`.
